// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b one bit per clock, LSB first, with one full-subtractor cell and a borrow flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] ra, rb, rd;
    logic [CW-1:0] cnt;
    logic br;
    logic d, br_next;
    assign d       = ra[0] ^ rb[0] ^ br;
    assign br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ra             <= '0;
            rb             <= '0;
            rd             <= '0;
            cnt            <= '0;
            br             <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    ra       <= bus.a;
                    rb       <= bus.b;
                    br       <= 1'b0;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    ra <= ra >> 1;
                    rb <= rb >> 1;
                    rd <= {d, rd[WIDTH-1:1]};
                    br <= br_next;
                    // cnt holds on the final bit so it never wraps
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.diff       <= {d, rd[WIDTH-1:1]};
                        bus.borrow_out <= br_next;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor in the adders library, the complementary (difference/borrow) counterpart of the combinational half/full adders. It computes `a - b` one bit per clock, LSB first, using a single half/full-subtractor cell and a borrow flip-flop. A start/busy/done handshake sequences each operation. It is the area-minimal subtraction option for datapaths that can accept WIDTH-cycle latency.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal range 2..32.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset: asynchronous assert, active-low.
- `start`  input  1  request a new operation; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled on the accepting edge only.
- `b`  input  WIDTH  subtrahend; sampled on the accepting edge only.
- `busy`  output  1  high from the accepting edge until return to IDLE, DONE cycle included.
- `done`  output  1  one-cycle pulse; `diff` and `borrow_out` are valid and stable.
- `diff`  output  WIDTH  registered result `(a - b) mod 2^WIDTH`.
- `borrow_out`  output  1  registered final borrow; 1 when `a < b` (unsigned).

## Operation
- FSM states:
  - IDLE: `busy`=0. `start`=1 loads `a` and `b` into shift registers `ra` and `rb`, clears the borrow flop `br` and the bit counter `cnt`, then goes to SHIFT.
  - SHIFT: each cycle does the following:
    - `d = ra[0] ^ rb[0] ^ br`.
    - `br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)`.
    - `ra` and `rb` shift right by one.
    - Internal result register `rd` shifts right with `d` inserted at the MSB.
    - `cnt` increments.
    - When `cnt == WIDTH-1`, the next state is DONE. On that same edge, `diff` gets the final `rd` value (including the current `d`) and `borrow_out` gets `br_next`.
  - DONE: `done`=1 and `busy`=1 for exactly one cycle, then unconditionally back to IDLE.
- `diff` and `borrow_out` update only on the SHIFT→DONE edge. They hold the previous result during a computation and hold the result indefinitely in IDLE.
- `start` asserted in SHIFT or DONE is ignored. It is not queued. The operation in flight is unaffected.
- `start` held high continuously gives back-to-back operations: one IDLE cycle between DONE and the next SHIFT, where the new operands are accepted.
- `a` and `b` may change freely after the accepting edge.
- `cnt` width is `$clog2(WIDTH)`. Do not let `cnt` wrap inside SHIFT.

## Timing
- Reset (`rst_n`=0, asynchronous) sets the following, and all hold while `rst_n`=0:
  - state=IDLE
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0
  - `ra`, `rb`, `rd`, `br`, `cnt` all 0
- Reset deassertion is synchronous to `clk`. The first `start` is accepted on the first rising edge with `rst_n`=1.
- Reset mid-operation aborts immediately. No `done` is produced, and `diff` returns to 0.
- Let the accepting edge be E0.
  - `busy` rises after E0.
  - The SHIFT cycles are the cycles following edges E0..E0+WIDTH-1.
  - `done`, `diff` and `borrow_out` become valid after edge E0+WIDTH.
  - `busy` and `done` fall after edge E0+WIDTH+1.
- Latency is WIDTH cycles from accept to `done`. Throughput is one operation per WIDTH+2 cycles.
- Boundary cases:
  - `a == b` gives `diff`=0, `borrow_out`=0.
  - `b == 0` gives `diff=a`, `borrow_out`=0.
  - `a=0`, `b=1` gives all-ones with `borrow_out`=1. This is the maximum borrow ripple across every bit.

## Test plan
- Reset, then `start` with a=8'd5, b=8'd3 (WIDTH=8). Required: `done` exactly 8 cycles after accept, `diff`=8'd2, `borrow_out`=0. `busy` is high for 9 cycles in total.
- a=8'd3, b=8'd5. Required: `diff`=8'd254, `borrow_out`=1. Then a=8'd0, b=8'd1. Required: `diff`=8'hFF, `borrow_out`=1. Then a=b=8'hFF. Required: `diff`=0, `borrow_out`=0.
- Accept a=8'd200, b=8'd55. Pulse `start` with a=8'd1, b=8'd2 during SHIFT and again during DONE. Required: a single `done`, `diff`=8'd145, `borrow_out`=0, and no second operation starts.
- Hold `start`=1 with operand pairs (10,4) and then (4,10). Required: first `done` with `diff`=6, `borrow_out`=0; one IDLE cycle; second `done` with `diff`=250, `borrow_out`=1. `diff` holds 6 until the second result edge.
- Drive `rst_n`=0 asynchronously (between clock edges) in the 4th SHIFT cycle of a=8'd9, b=8'd1. Required: `busy`, `done`, `diff` and `borrow_out` are 0 immediately and remain 0 with no `done` pulse. After release, a new a=8'd9, b=8'd1 gives `diff`=8'd8.
- Randomised self-check: 1000 random (a, b) pairs at WIDTH=8 and WIDTH=16. Compare against `{borrow_out, diff} == {1'b0, a} - {1'b0, b}` on every `done`.
